// File: rtl/filter_ctrl_pkg.sv
// Shared types and defaults for the chroma carrier mode controller.
// States, default cycle counts and the signed chroma sample type.
package filter_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN,
    WAIT_LINE,
    FLUSH,
    SETTLE,
    FADE
  } state_t;

  localparam int DEF_FLUSH_CYCLES     = 4;
  localparam int DEF_SETTLE_CYCLES    = 64;
  localparam int DEF_FADE_STEP_CYCLES = 16;
  localparam int FADE_GAIN_MAX        = 8;

  typedef logic signed [7:0] sample_t;

endpackage

// File: rtl/filter_gain_ramp.sv
// Fade-in gain k=1..8 stepping every STEP_CYCLES; scaled = (sample*k_next)>>>3, combinational.
// The caller registers the result; k_next is the gain for the cycle being loaded. No backpressure.
module filter_gain_ramp
  import filter_ctrl_pkg::*;
#(
  parameter int STEP_CYCLES = DEF_FADE_STEP_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enter,
  input  logic        active,
  input  logic signed [7:0] sample,
  output logic signed [7:0] scaled
);

  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  typedef logic [SW-1:0] step_t;
  localparam step_t STEP_LOAD = step_t'(STEP_CYCLES - 1);

  logic [3:0]          k, k_nxt;
  step_t               step, step_nxt;
  logic signed [11:0]  prod;
  logic signed [11:0]  shifted;

  always_comb begin
    k_nxt    = k;
    step_nxt = step;
    if (enter) begin
      k_nxt    = 4'd1;
      step_nxt = STEP_LOAD;
    end else if (active) begin
      if (step == '0) begin
        if (k != 4'(FADE_GAIN_MAX)) k_nxt = k + 4'd1;
        step_nxt = STEP_LOAD;
      end else begin
        step_nxt = step - step_t'(1);
      end
    end
  end

  // 12-bit signed product, arithmetic shift rounds toward minus infinity
  assign prod    = $signed({{4{sample[7]}}, sample}) * $signed({8'd0, k_nxt});
  assign shifted = prod >>> 3;
  assign scaled  = shifted[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      k    <= '0;
      step <= '0;
    end else begin
      k    <= k_nxt;
      step <= step_nxt;
    end
  end

endmodule

// File: rtl/filter_carrier_mode_ctrl.sv
// PAL/NTSC switch sequencer for the chroma IIR: apply at line start, flush, mute while settling.
// RUN latency filt_in->out 1 cycle; no backpressure. Optional fade-in: FILTER_CARRIER_CTRL_FADE_EN.
module filter_carrier_mode_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter bit RESET_PAL        = 1'b1,
  parameter int FLUSH_CYCLES     = DEF_FLUSH_CYCLES,
  parameter int SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
  parameter int FADE_STEP_CYCLES = DEF_FADE_STEP_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pal_mode_req,
  input  logic              line_start,
  input  logic signed [7:0] filt_in,
  output logic              pal_mode,
  output logic              filter_clear,
  output logic signed [7:0] out,
  output logic              busy
);

  localparam int FADE_CYCLES = FADE_GAIN_MAX * FADE_STEP_CYCLES;
  localparam int MAX_A   = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > FADE_CYCLES) ? MAX_A : FADE_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t FLUSH_LOAD  = cnt_t'(FLUSH_CYCLES - 1);
  localparam cnt_t SETTLE_LOAD = cnt_t'(SETTLE_CYCLES - 1);

  state_t  state, state_nxt;
  cnt_t    cnt, cnt_nxt;
  logic    pal_nxt;
  sample_t out_nxt;

`ifdef FILTER_CARRIER_CTRL_FADE_EN
  localparam cnt_t FADE_LOAD = cnt_t'(FADE_CYCLES - 1);
  sample_t fade_out;

  filter_gain_ramp #(
    .STEP_CYCLES(FADE_STEP_CYCLES)
  ) u_gain_ramp (
    .clk    (clk),
    .reset  (reset),
    .enter  ((state == SETTLE) && (state_nxt == FADE)),
    .active (state == FADE),
    .sample (filt_in),
    .scaled (fade_out)
  );
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pal_nxt   = pal_mode;
    case (state)
      RUN: begin
        if (pal_mode_req != pal_mode) begin
          if (line_start) begin
            state_nxt = FLUSH;
            cnt_nxt   = FLUSH_LOAD;
            pal_nxt   = pal_mode_req;
          end else begin
            state_nxt = WAIT_LINE;
          end
        end
      end
      WAIT_LINE: begin
        // a withdrawn request wins over a coincident line start
        if (pal_mode_req == pal_mode) begin
          state_nxt = RUN;
        end else if (line_start) begin
          state_nxt = FLUSH;
          cnt_nxt   = FLUSH_LOAD;
          pal_nxt   = pal_mode_req;
        end
      end
      FLUSH: begin
        if (cnt == '0) begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_LOAD;
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
`ifdef FILTER_CARRIER_CTRL_FADE_EN
          state_nxt = FADE;
          cnt_nxt   = FADE_LOAD;
`else
          state_nxt = RUN;
`endif
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end
`ifdef FILTER_CARRIER_CTRL_FADE_EN
      FADE: begin
        if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - cnt_t'(1);
        end
      end
`endif
      default: begin
        state_nxt = FLUSH;
        cnt_nxt   = FLUSH_LOAD;
      end
    endcase
  end

  // outputs are registered from the next state so they line up with the state register
  always_comb begin
    out_nxt = '0;
    case (state_nxt)
      RUN, WAIT_LINE: out_nxt = filt_in;
`ifdef FILTER_CARRIER_CTRL_FADE_EN
      FADE:           out_nxt = fade_out;
`endif
      default:        out_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FLUSH;
      cnt          <= FLUSH_LOAD;
      pal_mode     <= RESET_PAL;
      filter_clear <= 1'b1;
      out          <= '0;
      busy         <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pal_mode     <= pal_nxt;
      filter_clear <= (state_nxt == FLUSH);
      out          <= out_nxt;
      busy         <= (state_nxt != RUN);
    end
  end

endmodule
